// File: rtl/paddle_ctrl.sv
// paddle_ctrl: tick-driven paddle position with held-button acceleration, wall clamping and ball-tracking auto mode
module paddle_ctrl #(
  parameter int SCREEN_H    = 480,
  parameter int PADDLE_H    = 80,
  parameter int Y_W         = 10,
  parameter int STEP        = 4,
  parameter int MAX_STEP    = 16,
  parameter int ACCEL_TICKS = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick,
  input  logic           user_up,
  input  logic           user_down,
  input  logic           auto_mode,
  input  logic [Y_W-1:0] ball_y,
  output logic [Y_W-1:0] paddle_y,
  output logic           moving,
  output logic           at_top,
  output logic           at_bottom
);
  localparam int HW = $clog2(ACCEL_TICKS + 1);
  localparam logic [Y_W:0] MAX_Y  = (Y_W+1)'(SCREEN_H - PADDLE_H);
  localparam logic [Y_W:0] STEP_W = (Y_W+1)'(STEP);
  localparam logic [Y_W:0] MAX_S  = (Y_W+1)'(MAX_STEP);
  localparam logic [Y_W:0] HALF   = (Y_W+1)'(PADDLE_H / 2);
  localparam logic [HW-1:0] ACC   = HW'(ACCEL_TICKS);
  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN} state_t;
  state_t state_q, state_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [Y_W:0] speed_q, speed_d, y_x, y_n, y_up, y_dn, sum, tgt_raw, tgt, sp_inc;
  logic [HW-1:0] hold_q, hold_d, hc;
  logic moving_q, moving_d, top_q, top_d, bot_q, bot_d;
  logic up_s1_q, up_s2_q, dn_s1_q, dn_s2_q, up, dn, same;
  always_comb begin
    state_d  = state_q;
    speed_d  = speed_q;
    hold_d   = hold_q;
    y_d      = y_q;
    moving_d = moving_q;
    top_d    = top_q;
    bot_d    = bot_q;
    up       = up_s2_q & ~dn_s2_q;
    dn       = dn_s2_q & ~up_s2_q;
    same     = (state_q == MOVE_UP) ? up : (state_q == MOVE_DOWN) ? dn : 1'b0;
    y_x      = {1'b0, y_q};
    y_up     = (y_x < speed_q) ? '0 : y_x - speed_q;
    sum      = y_x + speed_q;
    y_dn     = (sum > MAX_Y) ? MAX_Y : sum;
    tgt_raw  = ({1'b0, ball_y} < HALF) ? '0 : {1'b0, ball_y} - HALF;
    tgt      = (tgt_raw > MAX_Y) ? MAX_Y : tgt_raw;
    sp_inc   = speed_q + STEP_W;
    hc       = hold_q + 1'b1;
    y_n      = y_x;
    if (tick) begin
      if (auto_mode) begin
        state_d = IDLE;
        speed_d = STEP_W;
        hold_d  = '0;
        y_n     = (tgt > y_x) ? ((tgt - y_x <= STEP_W) ? tgt : y_x + STEP_W)
                              : ((y_x - tgt <= STEP_W) ? tgt : y_x - STEP_W);
      end else if (same) begin
        y_n     = (state_q == MOVE_UP) ? y_up : y_dn;
        hold_d  = (hc == ACC) ? '0 : hc;
        speed_d = (hc == ACC) ? ((sp_inc > MAX_S) ? MAX_S : sp_inc) : speed_q;
      end else begin
        state_d = up ? MOVE_UP : dn ? MOVE_DOWN : IDLE;
        speed_d = STEP_W;
        hold_d  = '0;
      end
      y_d      = y_n[Y_W-1:0];
      moving_d = (y_n != y_x);
      top_d    = (y_n == '0);
      bot_d    = (y_n == MAX_Y);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      speed_q  <= STEP_W;
      hold_q   <= '0;
      y_q      <= Y_W'(MAX_Y / 2);
      moving_q <= 1'b0;
      top_q    <= 1'b0;
      bot_q    <= 1'b0;
      up_s1_q  <= 1'b0;
      up_s2_q  <= 1'b0;
      dn_s1_q  <= 1'b0;
      dn_s2_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      speed_q  <= speed_d;
      hold_q   <= hold_d;
      y_q      <= y_d;
      moving_q <= moving_d;
      top_q    <= top_d;
      bot_q    <= bot_d;
      up_s1_q  <= user_up;
      up_s2_q  <= up_s1_q;
      dn_s1_q  <= user_down;
      dn_s2_q  <= dn_s1_q;
    end
  end
  assign paddle_y  = y_q;
  assign moving    = moving_q;
  assign at_top    = top_q;
  assign at_bottom = bot_q;
endmodule
